vu_vmu_load_data_queue: RTL

- Vector load data queue (VLDQ) directly downstream of the VMU vector control block.
- Accepts 65-bit writeback elements from the load writeback stage and buffers them in order.
- Presents them to the lane writeback port one element per dequeue.
- Tracks how many complete vectors are resident using the bit-64 "last element" marker, so lanes start a vector writeback only when the whole vector is buffered.

---
 rtl/vu_vmu_load_data_queue.sv | 87 ++++++++
 1 files changed

// File: rtl/vu_vmu_load_data_queue.sv
// Vector load data queue: in-order 65-bit element buffer with a count of resident complete vectors.
// Latency: an element enqueued at edge N is visible at the head after edge N; there is no empty bypass.
// Backpressure: enq_rdy = ~full from registered state only; deq_rdy is ignored while the queue is empty.
module vu_vmu_load_data_queue #(
    parameter int DEPTH   = 16,
    parameter int ADDR_SZ = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enq_val,
    output logic               enq_rdy,
    input  logic [64:0]        enq_bits,
    output logic               deq_val,
    input  logic               deq_rdy,
    output logic [64:0]        deq_bits,
    output logic [ADDR_SZ:0]   count,
    output logic               vec_avail,
    output logic [ADDR_SZ:0]   vec_cnt
);

    localparam logic [ADDR_SZ:0] ONE = (ADDR_SZ+1)'(1);

    logic [64:0]      mem [DEPTH];
    logic [ADDR_SZ:0] head;
    logic [ADDR_SZ:0] tail;
    logic [ADDR_SZ:0] vec_cnt_q;
    logic             empty;
    logic             full;
    logic             enq_fire;
    logic             deq_fire;
    logic             vec_inc;
    logic             vec_dec;

    assign empty = (head == tail);
    // The wrap bit distinguishes full from empty when the index bits match.
    assign full  = (head[ADDR_SZ-1:0] == tail[ADDR_SZ-1:0]) && (head[ADDR_SZ] != tail[ADDR_SZ]);

    assign enq_rdy  = ~full;
    assign deq_val  = ~empty;
    assign deq_bits = mem[head[ADDR_SZ-1:0]];
    assign count    = tail - head;
    assign vec_cnt  = vec_cnt_q;
    assign vec_avail = (vec_cnt_q != '0);

    assign enq_fire = enq_val & enq_rdy;
    assign deq_fire = deq_val & deq_rdy;
    assign vec_inc  = enq_fire & enq_bits[64];
    assign vec_dec  = deq_fire & deq_bits[64];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head      <= '0;
            tail      <= '0;
            vec_cnt_q <= '0;
        end else begin
            if (enq_fire) begin
                tail <= tail + ONE;
            end
            if (deq_fire) begin
                head <= head + ONE;
            end
            case ({vec_inc, vec_dec})
                2'b10:   vec_cnt_q <= vec_cnt_q + ONE;
                2'b01:   vec_cnt_q <= vec_cnt_q - ONE;
                default: vec_cnt_q <= vec_cnt_q;
            endcase
        end
    end

    // Storage is deliberately left uncleared on reset; deq_bits is don't-care while empty.
    always_ff @(posedge clk) begin
        if (enq_fire) begin
            mem[tail[ADDR_SZ-1:0]] <= enq_bits;
        end
    end

`ifndef SYNTHESIS
    a_enq_stable: assert property (@(posedge clk) disable iff (reset)
        (enq_val && !enq_rdy) |=> (!enq_val || $stable(enq_bits)))
        else $error("enq_bits changed while enq_val held against enq_rdy=0");

    a_vec_le_count: assert property (@(posedge clk) disable iff (reset)
        vec_cnt_q <= count)
        else $error("vec_cnt exceeds count");
`endif

endmodule
